// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencer, single-outstanding req/ack IMEM port and a
// prefetch FIFO presented to decode over valid/ready. Redirects flush and kill in-flight fetches.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [ILEN-1:0]   data_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];

  logic              push, pop, can_issue;
  logic [XLEN-1:0]   addr_plus4;
  logic [XLEN-1:0]   redir_pc;

  // A redirect discards any same-cycle push or pop.
  assign push       = (state_q == StWait) && imem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign addr_plus4 = addr_q + XLEN'(4);
  assign redir_pc   = redirect_pc & ~XLEN'(3);

  // FIFO occupancy and pointers
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (redirect) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Issue only when the FIFO will still have room after this edge.
  assign can_issue = (count_d < CntW'(DEPTH));

  // Fetch sequencer
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d = redir_pc;
      case (state_q)
        StIdle: begin
          req_d   = 1'b1;
          addr_d  = redir_pc;
          state_d = StWait;
        end
        StWait, StDrain: begin
          // An ack this cycle retires the old request, so the new one can go out now.
          if (imem_ack) begin
            req_d   = 1'b1;
            addr_d  = redir_pc;
            state_d = StWait;
          end else begin
            state_d = StDrain;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      endcase
    end else begin
      case (state_q)
        StIdle: begin
          if (can_issue) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem_ack) begin
            pc_d = addr_plus4;
            if (can_issue) begin
              addr_d = addr_plus4;
            end else begin
              req_d   = 1'b0;
              state_d = StIdle;
            end
          end
        end
        StDrain: begin
          if (imem_ack) begin
            addr_d  = pc_q;
            state_d = StWait;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr_q] <= imem_rdata;
      pc_mem[wptr_q]   <= addr_q;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem[rptr_q];
  assign inst_pc    = pc_mem[rptr_q];

endmodule
